// File: rtl/mmu_tile_scheduler.sv
// Sequences one decoded matrix-multiply instruction over the systolic array:
// weight-tile loads, compute passes and accumulator drains, u outer, k inner.
module mmu_tile_scheduler #(
  parameter int MUL_SIZE   = 32,
  parameter int INSTR_SIZE = 72
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [INSTR_SIZE-1:0] instr,
  output logic                  instr_ready,
  output logic                  wl_valid,
  input  logic                  wl_ready,
  output logic [6:0]            wl_tile_u,
  output logic [6:0]            wl_tile_k,
  input  logic                  wl_done,
  output logic                  mac_valid,
  input  logic                  mac_ready,
  output logic [11:0]           mac_rd_addr,
  output logic [7:0]            mac_rows,
  output logic                  mac_acc_clear,
  input  logic                  mac_done,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic [11:0]           drain_wr_addr,
  output logic [7:0]            drain_rows,
  output logic                  drain_mode,
  input  logic                  drain_done,
  output logic                  busy,
  output logic                  done,
  output logic                  op_err
);

  typedef struct packed {
    logic [2:0]  mac_op;
    logic [7:0]  v_dim;
    logic [7:0]  u_dim;
    logic [7:0]  iter_dim;
    logic [6:0]  v_dim1;
    logic [6:0]  u_dim1;
    logic [6:0]  iter_dim1;
    logic [11:0] ub_rd_start;
    logic [11:0] ub_wr_start;
  } decoded_instr_t;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_LOAD_W, S_WAIT_W, S_COMPUTE,
    S_WAIT_C, S_DRAIN, S_WAIT_D, S_DONE
  } state_t;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_MATMUL_A = 3'd2;
  localparam logic [2:0] OP_DIAG     = 3'd3;

  decoded_instr_t in_s;
  assign in_s = instr;

  // Fields carried by the instruction word but not needed for sequencing.
  logic [31:0] unused_fields;
  assign unused_fields = {in_s.u_dim, in_s.iter_dim, in_s.v_dim1, 9'(MUL_SIZE)};

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  v_dim_q, v_dim_d;
  logic [6:0]  u1_q, u1_d, k1_q, k1_d;
  logic [6:0]  u_q, u_d, k_q, k_d;
  logic [11:0] rd_start_q, rd_start_d;
  logic [11:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic        err_q, err_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    v_dim_d    = v_dim_q;
    u1_d       = u1_q;
    k1_d       = k1_q;
    u_d        = u_q;
    k_d        = k_q;
    rd_start_d = rd_start_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        op_d       = in_s.mac_op;
        v_dim_d    = in_s.v_dim;
        u1_d       = in_s.u_dim1;
        k1_d       = in_s.iter_dim1;
        rd_start_d = in_s.ub_rd_start;
        rd_ptr_d   = in_s.ub_rd_start;
        wr_ptr_d   = in_s.ub_wr_start;
        u_d        = '0;
        k_d        = '0;
        err_d      = 1'b0;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        if (op_q[2]) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (op_q == OP_NOP || v_dim_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W:  if (wl_ready)    state_d = S_WAIT_W;
      S_WAIT_W:  if (wl_done)     state_d = S_COMPUTE;
      S_COMPUTE: if (mac_ready)   state_d = S_WAIT_C;
      S_WAIT_C: if (mac_done) begin
        rd_ptr_d = rd_ptr_q + {4'd0, v_dim_q};
        if (k_q < k1_q) begin
          k_d     = k_q + 7'd1;
          state_d = S_LOAD_W;
        end else begin
          k_d     = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN:   if (drain_ready) state_d = S_WAIT_D;
      S_WAIT_D: if (drain_done) begin
        wr_ptr_d = wr_ptr_q + {4'd0, v_dim_q};
        if (u_q < u1_q) begin
          u_d      = u_q + 7'd1;
          rd_ptr_d = rd_start_q;
          state_d  = S_LOAD_W;
        end else begin
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      v_dim_q    <= '0;
      u1_q       <= '0;
      k1_q       <= '0;
      u_q        <= '0;
      k_q        <= '0;
      rd_start_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      v_dim_q    <= v_dim_d;
      u1_q       <= u1_d;
      k1_q       <= k1_d;
      u_q        <= u_d;
      k_q        <= k_d;
      rd_start_q <= rd_start_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      err_q      <= err_d;
    end
  end

  // Moore outputs: each valid is its command state, payload held by registers.
  assign instr_ready   = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign op_err        = (state_q == S_DONE) && err_q;
  assign wl_valid      = (state_q == S_LOAD_W);
  assign wl_tile_u     = u_q;
  assign wl_tile_k     = k_q;
  assign mac_valid     = (state_q == S_COMPUTE);
  assign mac_rd_addr   = rd_ptr_q;
  assign mac_rows      = v_dim_q;
  assign mac_acc_clear = (state_q == S_COMPUTE) && (k_q == 7'd0) && (op_q != OP_MATMUL_A);
  assign drain_valid   = (state_q == S_DRAIN);
  assign drain_wr_addr = wr_ptr_q;
  assign drain_rows    = v_dim_q;
  assign drain_mode    = (state_q == S_DRAIN) && (op_q == OP_DIAG);

endmodule

// File: tb/tb_mmu_tile_scheduler.sv
// Directed bench for mmu_tile_scheduler: a table of instructions with
// hand-computed command counts/addresses, plus stall and reset sequences.
module tb_mmu_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [71:0] instr;
  logic        instr_ready;
  logic        wl_valid, wl_ready, wl_done;
  logic [6:0]  wl_tile_u, wl_tile_k;
  logic        mac_valid, mac_ready, mac_acc_clear, mac_done;
  logic [11:0] mac_rd_addr;
  logic [7:0]  mac_rows;
  logic        drain_valid, drain_ready, drain_mode, drain_done;
  logic [11:0] drain_wr_addr;
  logic [7:0]  drain_rows;
  logic        busy, done, op_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmu_tile_scheduler #(.MUL_SIZE(32), .INSTR_SIZE(72)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .wl_valid(wl_valid), .wl_ready(wl_ready), .wl_tile_u(wl_tile_u),
    .wl_tile_k(wl_tile_k), .wl_done(wl_done),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_rd_addr(mac_rd_addr),
    .mac_rows(mac_rows), .mac_acc_clear(mac_acc_clear), .mac_done(mac_done),
    .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_wr_addr(drain_wr_addr), .drain_rows(drain_rows),
    .drain_mode(drain_mode), .drain_done(drain_done),
    .busy(busy), .done(done), .op_err(op_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  vdim;
    logic [6:0]  u1;
    logic [6:0]  k1;
    logic [11:0] rd;
    logic [11:0] wr;
    bit          stall;
    int          exp_loads;
    int          exp_drains;
    bit          exp_err;
    logic [11:0] exp_last_rd;
    logic [11:0] exp_last_wr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic vld(input int which);
    case (which)
      0:       return wl_valid;
      1:       return mac_valid;
      default: return drain_valid;
    endcase
  endfunction

  function automatic logic [31:0] payload(input int which);
    case (which)
      0:       return {18'd0, wl_tile_u, wl_tile_k};
      1:       return {11'd0, mac_rd_addr, mac_rows, mac_acc_clear};
      default: return {11'd0, drain_wr_addr, drain_rows, drain_mode};
    endcase
  endfunction

  task automatic set_ready(input int which, input logic val);
    case (which)
      0:       wl_ready = val;
      1:       mac_ready = val;
      default: drain_ready = val;
    endcase
  endtask

  task automatic set_done(input int which, input logic val);
    case (which)
      0:       wl_done = val;
      1:       mac_done = val;
      default: drain_done = val;
    endcase
  endtask

  task automatic wait_valid(input int which, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (vld(which)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout actual=no_valid required=valid", name);
    end
  endtask

  // Called at a negedge with the command valid visible; returns at the negedge
  // right after the matching done pulse was taken.
  task automatic handshake(input int which, input bit stall, input string tag);
    logic [31:0] p;
    p = payload(which);
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk({tag, ".hold"}, {vld(which), payload(which)}, {1'b1, p});
      end
    end
    set_ready(which, 1'b1);
    @(negedge clk);
    set_ready(which, 1'b0);
    chk({tag, ".accepted"}, {wl_valid, mac_valid, drain_valid, busy}, 4'b0001);
    if (stall && which == 0) begin
      drain_done = 1'b1;
      mac_done   = 1'b1;
      @(negedge clk);
      drain_done = 1'b0;
      mac_done   = 1'b0;
      chk({tag, ".spurious"}, {wl_valid, mac_valid, drain_valid, busy}, 4'b0001);
    end
    set_done(which, 1'b1);
    @(negedge clk);
    set_done(which, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit          ok;
    bit          nocmd;
    int          loads, drains;
    logic [11:0] last_rd, last_wr, e_rd, e_wr;
    loads   = 0;
    drains  = 0;
    last_rd = '0;
    last_wr = '0;
    nocmd   = (v.op == 3'd0) || (v.op >= 3'd4) || (v.vdim == 8'd0);
    @(negedge clk);
    chk({tag, ".instr_ready"}, instr_ready, 1'b1);
    instr = {v.op, v.vdim, 8'd0, 8'd0, 7'd0, v.u1, v.k1, v.rd, v.wr};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = '1;
    chk({tag, ".decode"}, {busy, instr_ready, wl_valid, mac_valid, drain_valid, done}, 6'b100000);
    @(negedge clk);
    if (nocmd) begin
      chk({tag, ".retire"}, {done, op_err, wl_valid, mac_valid, drain_valid},
          {1'b1, v.exp_err, 3'b000});
    end else begin
      chk({tag, ".wl_first"}, wl_valid, 1'b1);
      for (int u = 0; u <= int'(v.u1); u++) begin
        for (int k = 0; k <= int'(v.k1); k++) begin
          wait_valid(0, {tag, ".wl_wait"}, ok);
          if (!ok) return;
          chk({tag, ".wl_tile"}, {wl_tile_u, wl_tile_k}, {7'(u), 7'(k)});
          chk({tag, ".wl_order"}, {mac_valid, drain_valid}, 2'b00);
          handshake(0, v.stall, tag);
          wait_valid(1, {tag, ".mac_wait"}, ok);
          if (!ok) return;
          e_rd = v.rd + 12'(k * int'(v.vdim));
          chk({tag, ".mac"}, {mac_rd_addr, mac_rows, mac_acc_clear},
              {e_rd, v.vdim, (k == 0) && (v.op != 3'd2)});
          last_rd = mac_rd_addr;
          loads++;
          handshake(1, v.stall, tag);
        end
        wait_valid(2, {tag, ".drain_wait"}, ok);
        if (!ok) return;
        e_wr = v.wr + 12'(u * int'(v.vdim));
        chk({tag, ".drain"}, {drain_wr_addr, drain_rows, drain_mode},
            {e_wr, v.vdim, v.op == 3'd3});
        last_wr = drain_wr_addr;
        drains++;
        handshake(2, 1'b0, tag);
      end
      chk({tag, ".retire"}, {done, op_err, busy, instr_ready}, 4'b1010);
      chk({tag, ".last_rd"}, last_rd, v.exp_last_rd);
      chk({tag, ".last_wr"}, last_wr, v.exp_last_wr);
    end
    chk({tag, ".loads"}, loads, v.exp_loads);
    chk({tag, ".drains"}, drains, v.exp_drains);
    @(negedge clk);
    chk({tag, ".idle"}, {instr_ready, busy, done, op_err}, 4'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    //          op    vdim  u1 k1  rd       wr       stl ld dr err last_rd  last_wr
    vecs[0] = '{3'd1, 8'd16, 7'd0, 7'd0, 12'h100, 12'h200, 1'b0, 1, 1, 1'b0, 12'h100, 12'h200};
    vecs[1] = '{3'd1, 8'd8,  7'd1, 7'd2, 12'h000, 12'h040, 1'b0, 6, 2, 1'b0, 12'h010, 12'h048};
    vecs[2] = '{3'd3, 8'd16, 7'd0, 7'd1, 12'hFF8, 12'h300, 1'b0, 2, 1, 1'b0, 12'h008, 12'h300};
    vecs[3] = '{3'd0, 8'd16, 7'd1, 7'd1, 12'h010, 12'h020, 1'b0, 0, 0, 1'b0, 12'h000, 12'h000};
    vecs[4] = '{3'd6, 8'd16, 7'd1, 7'd1, 12'h010, 12'h020, 1'b0, 0, 0, 1'b1, 12'h000, 12'h000};
    vecs[5] = '{3'd2, 8'd4,  7'd0, 7'd1, 12'h020, 12'h050, 1'b1, 2, 1, 1'b0, 12'h024, 12'h050};
    vecs[6] = '{3'd1, 8'd0,  7'd0, 7'd0, 12'h020, 12'h050, 1'b0, 0, 0, 1'b0, 12'h000, 12'h000};

    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    wl_ready = 1'b0; mac_ready = 1'b0; drain_ready = 1'b0;
    wl_done = 1'b0;  mac_done = 1'b0;  drain_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.outputs",
        {instr_ready, wl_valid, mac_valid, drain_valid, busy, done, op_err,
         mac_acc_clear, drain_mode, wl_tile_u, wl_tile_k, mac_rd_addr, drain_wr_addr},
        {1'b1, 8'd0, 14'd0, 24'd0});
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a compute pass is in flight.
    @(negedge clk);
    instr = {3'd1, 8'd8, 8'd0, 8'd0, 7'd0, 7'd1, 7'd1, 12'h123, 12'h456};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    wait_valid(0, "rst.wl_wait", ok);
    handshake(0, 1'b0, "rst");
    wait_valid(1, "rst.mac_wait", ok);
    mac_ready = 1'b1;
    @(negedge clk);
    mac_ready = 1'b0;
    chk("rst.in_wait_c", {busy, mac_valid, wl_valid}, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.async",
        {instr_ready, wl_valid, mac_valid, drain_valid, busy, done, op_err,
         mac_acc_clear, drain_mode, wl_tile_u, wl_tile_k, mac_rd_addr, drain_wr_addr, mac_rows},
        {1'b1, 8'd0, 14'd0, 24'd0, 8'd0});
    @(negedge clk);
    chk("rst.held", {instr_ready, busy, done}, 3'b100);
    rst_n = 1'b1;
    run_vec(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmu_tile_scheduler.md
# mmu_tile_scheduler

Sequences one decoded matrix-multiply instruction over the 32x32 systolic array. Accepts a `decoded_instr_t` from the decoder, walks the tile space (U tiles x ITER tiles), and issues, in order, weight-tile loads, activation-stream compute passes with unified-buffer read addresses, and accumulator drains with unified-buffer write addresses. Sits between the instruction decoder and the weight FIFO, MAC array and accumulator read-out logic; it is the single owner of those three command channels.

## Interface
- `MUL_SIZE`, 32: array dimension; informational only, tile size is implied.
- `INSTR_SIZE`, 72: width of `decoded_instr_t`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `instr_valid` in 1: decoded instruction present.
- `instr` in 72: `decoded_instr_t` {MAC_op, V_dim, U_dim, ITER_dim, V_dim1, U_dim1, ITER_dim1, ub_rd_start, ub_wr_start}.
- `instr_ready` out 1: scheduler idle, can accept.
- `wl_valid` out 1, `wl_ready` in 1: weight-load command handshake.
- `wl_tile_u` out 7, `wl_tile_k` out 7: tile coordinates of the weight tile.
- `wl_done` in 1: one-cycle pulse, weight tile resident in array.
- `mac_valid` out 1, `mac_ready` in 1: compute-pass handshake.
- `mac_rd_addr` out 12: UB start address of activation rows.
- `mac_rows` out 8: rows to stream (= V_dim).
- `mac_acc_clear` out 1: overwrite, not accumulate, this pass.
- `mac_done` in 1: pulse, compute pass finished.
- `drain_valid` out 1, `drain_ready` in 1: accumulator drain handshake.
- `drain_wr_addr` out 12: UB start address for results.
- `drain_rows` out 8: rows to drain (= V_dim).
- `drain_mode` out 1: `acc_rd_mode` (NORMAL=0, DIAG=1).
- `drain_done` in 1: pulse, drain complete.
- `busy` out 1: not in IDLE.
- `done` out 1: one-cycle pulse, instruction retired.
- `op_err` out 1: one-cycle pulse, reserved MAC_op retired.

## Operation
- MAC_op: 0 NOP, 1 MATMUL (clear at k=0), 2 MATMUL_ACC (never clear), 3 MATMUL_DIAG (as 1, drain in DIAG), 4-7 reserved.
- V_dim1/U_dim1/ITER_dim1 are tile counts minus one. U_dim, ITER_dim are not interpreted here.
- Loop: for u in 0..U_dim1 { for k in 0..ITER_dim1 { LOAD_W(u,k); COMPUTE } ; DRAIN(u) }. k innermost.
- Address rules, 12-bit, wrap modulo 4096: rd_ptr = ub_rd_start at each new u, += V_dim after each compute pass; wr_ptr = ub_wr_start at accept, += V_dim after each drain.
- `mac_acc_clear` = (k==0) && MAC_op != 2.
- States: IDLE -> (accept) DECODE -> LOAD_W -> WAIT_W -> COMPUTE -> WAIT_C -> {LOAD_W if k<ITER_dim1; DRAIN otherwise} ; DRAIN -> WAIT_D -> {LOAD_W if u<U_dim1; DONE otherwise}; DONE -> IDLE.
- DECODE: NOP or V_dim==0 -> DONE directly (no commands); reserved op -> DONE with `op_err`.
- Instruction fields latched on accept; `instr` ignored afterwards.
- Command valids rise on state entry, hold with stable payload until ready; state advances on valid&&ready. No valid drops without ready.
- `*_done` pulses accepted only in the matching WAIT state; otherwise ignored.

## Timing
- Reset: `instr_ready`=1, all other outputs 0, state IDLE, pointers/counters 0.
- `instr_ready` = (state==IDLE), combinational from state; accept when `instr_valid&&instr_ready`.
- Accept edge N: DECODE in N+1, `wl_valid` high in N+2.
- Command accepted edge M -> WAIT state from M+1; done pulse at edge P -> next command valid visible in P+1.
- `done` high exactly one cycle in DONE; `instr_ready` returns the following cycle. Back-to-back instructions: minimum 1 IDLE cycle.
- Reset asserted mid-instruction: immediate return to reset values; in-flight datapath commands abandoned, no `done`.

## Test plan
- MAC_op=1, V_dim=16, U_dim1=0, ITER_dim1=0, rd=0x100, wr=0x200 -> one wl(0,0), mac rd=0x100 rows=16 clear=1, drain wr=0x200 NORMAL, single `done`.
- MAC_op=1, V_dim=8, U_dim1=1, ITER_dim1=2, rd=0x000, wr=0x040 -> mac rd 0x000,0x008,0x010 clear 1,0,0 per u; drains at 0x040 then 0x048; 6 loads, 2 drains.
- MAC_op=3, rd=0xFF8, V_dim=16, ITER_dim1=1 -> second mac rd=0x008 (wrap), drain_mode=DIAG.
- `wl_ready`/`mac_ready` held low 5 cycles, spurious `drain_done` during WAIT_W -> valids and payloads stable, spurious pulse ignored.
- MAC_op=0 and MAC_op=6 -> no commands, `done` pulse; op 6 also `op_err`.
- `rst_n` low during WAIT_C -> all outputs at reset values same cycle, `instr_ready`=1; next instruction runs normally.
